useq_core: RTL and testbench

- Parametrised microsequencer core: next-microaddress generation, call/return stack and run/halt/step control for the KS10 microengine.
- Width, stack depth, reset vector and trap vector are parameters.
- Adds features the fixed 12-bit sequencer lacks:
  - stack overflow and underflow detection
  - microcode breakpoint
  - single-step
- Sits between the skip/dispatch logic and the synchronous control ROM; `addr` drives the ROM address directly.

---
 rtl/useq_core_if.sv | 41 ++++
 rtl/useq_core.sv | 125 ++++++++++++
 tb/tb_useq_core.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/useq_core_if.sv
// Sequencer-side bus of the KS10 microsequencer: microword control fields,
// run/halt controls and the address/stack status returned to the engine.
interface useq_core_if #(
    parameter int AW    = 12,
    parameter int DEPTH = 8
);
    localparam int DW = $clog2(DEPTH + 1);

    logic          clken;
    logic          trap;
    logic          call;
    logic          ret;
    logic [AW-1:0] jADDR;
    logic [AW-1:0] dispADDR;
    logic [AW-1:0] skipADDR;
    logic          halt;
    logic          cont;
    logic          step;
    logic          brkEN;
    logic [AW-1:0] brkADDR;
    logic [AW-1:0] addr;
    logic [AW-1:0] upc;
    logic [AW-1:0] retADDR;
    logic [DW-1:0] depth;
    logic          stkOVF;
    logic          stkUNF;
    logic          halted;
    logic          brkHIT;

    modport master (
        output clken, trap, call, ret, jADDR, dispADDR, skipADDR,
               halt, cont, step, brkEN, brkADDR,
        input  addr, upc, retADDR, depth, stkOVF, stkUNF, halted, brkHIT
    );

    modport slave (
        input  clken, trap, call, ret, jADDR, dispADDR, skipADDR,
               halt, cont, step, brkEN, brkADDR,
        output addr, upc, retADDR, depth, stkOVF, stkUNF, halted, brkHIT
    );
endinterface

// File: rtl/useq_core.sv
// Microsequencer core: next-microaddress mux, circular call/return stack with
// sticky overflow/underflow, and a RUN/HALT controller with breakpoint and step.
module useq_core #(
    parameter int            AW       = 12,
    parameter int            DEPTH    = 8,
    parameter logic [AW-1:0] RSTADDR  = '0,
    parameter logic [AW-1:0] TRAPADDR = '1
) (
    input logic       clk,
    input logic       rst,
    useq_core_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = $clog2(DEPTH + 1);

    typedef enum logic {RUN, HALT} state_e;

    state_e        state_q;
    logic          brk_hit_q;
    logic [AW-1:0] upc_q, upc_d;
    logic [PW-1:0] wp_q, wp_d;
    logic [DW-1:0] dep_q, dep_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [AW-1:0] stk_q [DEPTH];
    logic [AW-1:0] stk_d [DEPTH];

    logic          adv;
    logic [AW-1:0] addr_c;
    logic          push, pop, brk_match;
    logic [PW-1:0] top, wp_inc;

    assign adv = bus.clken & ((state_q == RUN) | ((state_q == HALT) & bus.step));

    always_comb begin
        addr_c = bus.jADDR | bus.dispADDR | bus.skipADDR;
        if (!rst)          addr_c = RSTADDR;
        else if (!adv)     addr_c = upc_q;
        else if (bus.trap) addr_c = TRAPADDR;
    end

    assign push      = adv & (bus.call | bus.trap);
    assign pop       = adv & bus.ret & ~bus.trap;
    assign brk_match = bus.brkEN & (addr_c == bus.brkADDR);

    // wp points at the next free slot, which is also the oldest entry when full
    assign top    = (wp_q == '0) ? PW'(DEPTH - 1) : wp_q - 1'b1;
    assign wp_inc = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;

    always_comb begin
        stk_d = stk_q;
        wp_d  = wp_q;
        dep_d = dep_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        upc_d = adv ? addr_c : upc_q;
        if (push && pop && dep_q != '0) begin
            stk_d[top] = addr_c;
        end else begin
            if (pop) begin
                if (dep_q == '0) begin
                    unf_d = 1'b1;
                end else begin
                    wp_d  = top;
                    dep_d = dep_q - 1'b1;
                end
            end
            if (push) begin
                stk_d[wp_q] = addr_c;
                wp_d        = wp_inc;
                if (dep_q == DW'(DEPTH)) ovf_d = 1'b1;
                else                     dep_d = dep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upc_q <= RSTADDR;
            wp_q  <= '0;
            dep_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            upc_q <= upc_d;
            wp_q  <= wp_d;
            dep_q <= dep_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack contents are don't-care after reset; depth gates their visibility
    always_ff @(posedge clk) begin
        stk_q <= stk_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            brk_hit_q <= 1'b0;
        end else if (bus.clken) begin
            case (state_q)
                RUN: begin
                    if (bus.halt || brk_match) state_q <= HALT;
                    if (brk_match) brk_hit_q <= 1'b1;
                end
                HALT: begin
                    if (bus.step)                    brk_hit_q <= 1'b0;
                    else if (bus.cont && !bus.halt) state_q   <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.addr    = addr_c;
    assign bus.upc     = upc_q;
    assign bus.retADDR = (dep_q != '0) ? stk_q[top] : '0;
    assign bus.depth   = dep_q;
    assign bus.stkOVF  = ovf_q;
    assign bus.stkUNF  = unf_q;
    assign bus.halted  = (state_q == HALT);
    assign bus.brkHIT  = brk_hit_q;
endmodule

// File: tb/tb_useq_core.sv
// Directed bench for useq_core (AW=12, DEPTH=4): flow, stack, trap, breakpoint,
// step/continue and asynchronous reset, against hand-computed values.
module tb_useq_core;
    localparam int AW = 12;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    useq_core_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

    useq_core #(
        .AW(AW), .DEPTH(DEPTH), .RSTADDR(12'o0000), .TRAPADDR(12'o7777)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0o exp=%0o", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flags(input string tag, input int d, input bit o, input bit u,
                         input bit h, input bit b);
        chk({tag, ".depth"},  32'(bus.depth),  32'(d));
        chk({tag, ".ovf"},    32'(bus.stkOVF), 32'(o));
        chk({tag, ".unf"},    32'(bus.stkUNF), 32'(u));
        chk({tag, ".halted"}, 32'(bus.halted), 32'(h));
        chk({tag, ".brkhit"}, 32'(bus.brkHIT), 32'(b));
    endtask

    initial begin
        bus.clken = 1'b1; bus.trap = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
        bus.jADDR = '0; bus.dispADDR = '0; bus.skipADDR = '0;
        bus.halt = 1'b0; bus.cont = 1'b0; bus.step = 1'b0;
        bus.brkEN = 1'b0; bus.brkADDR = '0;

        // reset held
        bus.jADDR = 12'o0001;
        #1;
        chk("rst.addr", 32'(bus.addr), 32'o0000);
        tick(); tick();
        chk("rst.addr_clk", 32'(bus.addr), 32'o0000);
        chk("rst.upc", 32'(bus.upc), 32'o0000);
        chk("rst.ret", 32'(bus.retADDR), 0);
        flags("rst", 0, 0, 0, 0, 0);
        rst = 1'b1;

        // sequential flow
        #1;
        chk("seq.addr1", 32'(bus.addr), 32'o0001);
        tick();
        chk("seq.upc1", 32'(bus.upc), 32'o0001);
        bus.jADDR = 12'o0002; bus.skipADDR = 12'o0004;
        #1;
        chk("seq.or", 32'(bus.addr), 32'o0006);
        bus.skipADDR = '0;
        tick();
        chk("seq.upc2", 32'(bus.upc), 32'o0002);
        bus.clken = 1'b0; bus.jADDR = 12'o0003;
        #1;
        chk("hold.addr", 32'(bus.addr), 32'o0002);
        tick();
        chk("hold.upc", 32'(bus.upc), 32'o0002);
        bus.clken = 1'b1;

        // call / return
        bus.jADDR = 12'o0100; bus.call = 1'b1;
        tick();
        chk("call.upc", 32'(bus.upc), 32'o0100);
        chk("call.ret", 32'(bus.retADDR), 32'o0100);
        chk("call.depth", 32'(bus.depth), 1);
        bus.call = 1'b0; bus.ret = 1'b1; bus.jADDR = 12'o0101;
        tick();
        chk("ret.depth", 32'(bus.depth), 0);
        chk("ret.ret", 32'(bus.retADDR), 0);
        bus.ret = 1'b0; bus.call = 1'b1; bus.jADDR = 12'o0110;
        tick();
        bus.ret = 1'b1; bus.jADDR = 12'o0120;
        tick();
        chk("cr.ret", 32'(bus.retADDR), 32'o0120);
        flags("cr", 1, 0, 0, 0, 0);
        bus.call = 1'b0; bus.jADDR = 12'o0000;
        tick();
        flags("cr.pop", 0, 0, 0, 0, 0);

        // overflow / underflow
        bus.ret = 1'b0; bus.call = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.jADDR = 12'(12'o0011 + i);
            tick();
        end
        chk("ovf.ret", 32'(bus.retADDR), 32'o0015);
        flags("ovf", 4, 1, 0, 0, 0);
        bus.call = 1'b0; bus.ret = 1'b1; bus.jADDR = 12'o0000;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pop%0d", i), 32'(bus.retADDR), 32'(12'o0015 - i));
            tick();
        end
        chk("pop.empty", 32'(bus.retADDR), 0);
        flags("pop4", 0, 1, 0, 0, 0);
        tick();
        chk("unf.ret", 32'(bus.retADDR), 0);
        flags("unf", 0, 1, 1, 0, 0);

        // trap beats ret and J
        bus.trap = 1'b1; bus.jADDR = 12'o0200;
        #1;
        chk("trap.addr", 32'(bus.addr), 32'o7777);
        tick();
        chk("trap.upc", 32'(bus.upc), 32'o7777);
        chk("trap.ret", 32'(bus.retADDR), 32'o7777);
        chk("trap.depth", 32'(bus.depth), 1);
        bus.trap = 1'b0;
        tick();
        chk("trap.pop", 32'(bus.depth), 0);
        bus.ret = 1'b0;

        // breakpoint, step, continue
        bus.brkEN = 1'b1; bus.brkADDR = 12'o0042; bus.jADDR = 12'o0041;
        tick();
        chk("brk.pre", 32'(bus.halted), 0);
        bus.jADDR = 12'o0042;
        tick();
        chk("brk.upc", 32'(bus.upc), 32'o0042);
        flags("brk", 0, 1, 1, 1, 1);
        bus.jADDR = 12'o0043;
        #1;
        chk("hlt.addr", 32'(bus.addr), 32'o0042);
        tick();
        chk("hlt.upc", 32'(bus.upc), 32'o0042);
        bus.step = 1'b1;
        #1;
        chk("step.addr", 32'(bus.addr), 32'o0043);
        tick();
        chk("step.upc", 32'(bus.upc), 32'o0043);
        flags("step", 0, 1, 1, 1, 0);
        bus.step = 1'b0; bus.jADDR = 12'o0044;
        tick();
        chk("step.once", 32'(bus.upc), 32'o0043);
        bus.cont = 1'b1; bus.halt = 1'b1;
        tick();
        chk("cont.blk", 32'(bus.halted), 1);
        bus.halt = 1'b0;
        tick();
        chk("cont.run", 32'(bus.halted), 0);
        chk("cont.upc", 32'(bus.upc), 32'o0043);
        bus.cont = 1'b0;
        tick();
        chk("run.upc", 32'(bus.upc), 32'o0044);

        // halt request, then async reset with a partly filled stack
        bus.brkEN = 1'b0; bus.call = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.jADDR = 12'(12'o0060 + i);
            tick();
        end
        bus.call = 1'b0; bus.halt = 1'b1; bus.jADDR = 12'o0063;
        tick();
        chk("halt.upc", 32'(bus.upc), 32'o0063);
        chk("halt.ret", 32'(bus.retADDR), 32'o0062);
        flags("halt", 3, 1, 1, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.addr", 32'(bus.addr), 32'o0000);
        chk("arst.upc", 32'(bus.upc), 32'o0000);
        chk("arst.ret", 32'(bus.retADDR), 0);
        flags("arst", 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
